// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Purpose  : NCH-channel PWM generator with boundary-buffered high/low reload,
//            one-shot, inversion, per-period done pulse and global sync.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi #(
    parameter int NCH   = 4,
    parameter int WIDTH = 16
) (
    input  logic                 mclk,
    input  logic                 h_reset,
    input  logic                 pulse1m_mclk,
    input  logic [NCH-1:0]       cfg_pwm_enb,
    input  logic [NCH-1:0]       cfg_pwm_oneshot,
    input  logic [NCH-1:0]       cfg_pwm_inv,
    input  logic [NCH*WIDTH-1:0] cfg_pwm_high,
    input  logic [NCH*WIDTH-1:0] cfg_pwm_low,
    input  logic [NCH-1:0]       cfg_pwm_upd,
    input  logic                 cfg_pwm_sync,
    output logic [NCH-1:0]       waveform,
    output logic [NCH-1:0]       pwm_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t           r_state;
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_act_high;
        logic [WIDTH-1:0] r_act_low;
        logic             r_upd_pend;
        logic             r_wave;
        logic             r_waveform;
        logic             r_done;
        logic [WIDTH-1:0] w_cfg_high;
        logic [WIDTH-1:0] w_cfg_low;
        logic             w_cnt_zero;

        assign w_cfg_high = cfg_pwm_high[c*WIDTH +: WIDTH];
        assign w_cfg_low  = cfg_pwm_low[c*WIDTH +: WIDTH];
        assign w_cnt_zero = (r_cnt == '0);

        // The output register follows the next raw wave, so every wave change
        // and every inversion toggle reaches the pin on the same edge.
        always_ff @(posedge mclk or posedge h_reset) begin
            if (h_reset) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_act_high <= '0;
                r_act_low  <= '0;
                r_upd_pend <= 1'b0;
                r_wave     <= 1'b0;
                r_waveform <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                r_done     <= 1'b0;
                r_waveform <= r_wave ^ cfg_pwm_inv[c];
                if (cfg_pwm_upd[c]) begin
                    r_upd_pend <= 1'b1;
                end
                if (r_state == S_IDLE) begin
                    r_act_high <= w_cfg_high;
                    r_act_low  <= w_cfg_low;
                end

                if (!cfg_pwm_enb[c]) begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_wave     <= 1'b0;
                    r_waveform <= cfg_pwm_inv[c];
                    r_upd_pend <= 1'b0;
                end else if (cfg_pwm_sync && (r_state != S_DONE)) begin
                    r_act_high <= w_cfg_high;
                    r_act_low  <= w_cfg_low;
                    r_cnt      <= w_cfg_high;
                    r_wave     <= 1'b1;
                    r_waveform <= ~cfg_pwm_inv[c];
                    r_state    <= S_HIGH;
                    r_upd_pend <= 1'b0;
                end else if (pulse1m_mclk) begin
                    case (r_state)
                        S_IDLE: begin
                            r_cnt      <= w_cfg_high;
                            r_wave     <= 1'b1;
                            r_waveform <= ~cfg_pwm_inv[c];
                            r_state    <= S_HIGH;
                        end
                        S_HIGH: begin
                            if (!w_cnt_zero) begin
                                r_cnt <= r_cnt - c_one;
                            end else begin
                                r_cnt      <= r_act_low;
                                r_wave     <= 1'b0;
                                r_waveform <= cfg_pwm_inv[c];
                                r_state    <= S_LOW;
                            end
                        end
                        S_LOW: begin
                            if (!w_cnt_zero) begin
                                r_cnt <= r_cnt - c_one;
                            end else begin
                                r_done <= 1'b1;
                                if (cfg_pwm_oneshot[c]) begin
                                    r_wave     <= 1'b0;
                                    r_waveform <= cfg_pwm_inv[c];
                                    r_state    <= S_DONE;
                                end else begin
                                    r_wave     <= 1'b1;
                                    r_waveform <= ~cfg_pwm_inv[c];
                                    r_state    <= S_HIGH;
                                    // An update request arriving on this very edge is consumed here.
                                    if (r_upd_pend || cfg_pwm_upd[c]) begin
                                        r_act_high <= w_cfg_high;
                                        r_act_low  <= w_cfg_low;
                                        r_cnt      <= w_cfg_high;
                                        r_upd_pend <= 1'b0;
                                    end else begin
                                        r_cnt <= r_act_high;
                                    end
                                end
                            end
                        end
                        default: begin
                            r_wave     <= 1'b0;
                            r_waveform <= cfg_pwm_inv[c];
                        end
                    endcase
                end
            end
        end

        assign waveform[c] = r_waveform;
        assign pwm_done[c] = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Purpose  : Directed, table-driven self-checking bench for pwm_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;

    logic                 mclk;
    logic                 h_reset;
    logic                 pulse1m_mclk;
    logic [NCH-1:0]       cfg_pwm_enb;
    logic [NCH-1:0]       cfg_pwm_oneshot;
    logic [NCH-1:0]       cfg_pwm_inv;
    logic [NCH*WIDTH-1:0] cfg_pwm_high;
    logic [NCH*WIDTH-1:0] cfg_pwm_low;
    logic [NCH-1:0]       cfg_pwm_upd;
    logic                 cfg_pwm_sync;
    logic [NCH-1:0]       waveform;
    logic [NCH-1:0]       pwm_done;

    int checks = 0;
    int errors = 0;

    pwm_multi #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .mclk            (mclk),
        .h_reset         (h_reset),
        .pulse1m_mclk    (pulse1m_mclk),
        .cfg_pwm_enb     (cfg_pwm_enb),
        .cfg_pwm_oneshot (cfg_pwm_oneshot),
        .cfg_pwm_inv     (cfg_pwm_inv),
        .cfg_pwm_high    (cfg_pwm_high),
        .cfg_pwm_low     (cfg_pwm_low),
        .cfg_pwm_upd     (cfg_pwm_upd),
        .cfg_pwm_sync    (cfg_pwm_sync),
        .waveform        (waveform),
        .pwm_done        (pwm_done)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] high;
        logic [15:0] low;
        logic        os;
        logic        inv;
        int          n;
        int          exp_high;
        int          exp_low;
        int          exp_done_idx;
        int          exp_done_cnt;
        int          exp_rise;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    // One tick cycle then one quiet cycle; outputs sampled right after the tick edge.
    task automatic tick(output logic [NCH-1:0] wf, output logic [NCH-1:0] dn);
        pulse1m_mclk = 1'b1;
        @(posedge mclk);
        #1;
        pulse1m_mclk = 1'b0;
        wf = waveform;
        dn = pwm_done;
        step();
    endtask

    task automatic set_ch(input int c, input logic [15:0] h, input logic [15:0] l, input logic os);
        cfg_pwm_high[c*WIDTH +: WIDTH] = h;
        cfg_pwm_low[c*WIDTH +: WIDTH]  = l;
        cfg_pwm_oneshot[c]             = os;
    endtask

    task automatic restart(input logic [NCH-1:0] en);
        cfg_pwm_enb = '0;
        step();
        cfg_pwm_enb = en;
        step();
    endtask

    // Tick 0 is the start tick; runs are measured on the raw (de-inverted) wave.
    task automatic measure(input int n, input logic inv, output int hi, output int lo,
                           output int didx, output int dcnt, output int rises);
        logic [NCH-1:0] wf, dn;
        logic raw, prev;
        int ph;
        hi = 0; lo = 0; didx = -1; dcnt = 0; rises = 0; ph = 0; prev = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick(wf, dn);
            raw = wf[0] ^ inv;
            if (dn[0]) begin
                dcnt++;
                if (didx < 0) didx = k;
            end
            if (k > 0 && raw && !prev) rises++;
            if (ph == 0) begin
                if (raw) hi++;
                else begin ph = 1; lo = 1; end
            end else if (ph == 1) begin
                if (!raw) lo++;
                else ph = 2;
            end
            prev = raw;
        end
    endtask

    function automatic logic [15:0] bits16(input string s);
        logic [15:0] b;
        for (int i = 0; i < 16; i++) b[15-i] = (s[i] == "1");
        return b;
    endfunction

    initial begin
        vec_t vecs[5];
        logic [NCH-1:0] wf, dn;
        logic [15:0] got;
        int hi, lo, didx, dcnt, rises;

        // high, low, oneshot, inv, ticks, exp high/low run, first done tick, dones, rises
        vecs[0] = '{16'd499, 16'd499, 1'b0, 1'b0, 1001, 500, 500, 1000, 1, 1};
        vecs[1] = '{16'd0,   16'd998, 1'b0, 1'b0, 1001, 1,   999, 1000, 1, 1};
        vecs[2] = '{16'd0,   16'd0,   1'b0, 1'b0, 8,    1,   1,   2,    3, 3};
        // one-shot: 3 low ticks, the period-end tick and 20 held ticks all read low
        vecs[3] = '{16'd3,   16'd2,   1'b1, 1'b0, 28,   4,   24,  7,    1, 0};
        vecs[4] = '{16'd2,   16'd1,   1'b0, 1'b1, 8,    3,   2,   5,    1, 1};

        h_reset = 1'b1; pulse1m_mclk = 1'b0; cfg_pwm_enb = '0; cfg_pwm_oneshot = '0;
        cfg_pwm_inv = '0; cfg_pwm_high = '0; cfg_pwm_low = '0; cfg_pwm_upd = '0;
        cfg_pwm_sync = 1'b0;
        step();
        cfg_pwm_inv[2] = 1'b1;
        step();
        check("reset_waveform", 32'(waveform), 32'd0);
        check("reset_done", 32'(pwm_done), 32'd0);
        h_reset = 1'b0;
        step();
        check("inv_after_reset", 32'(waveform[2]), 32'd1);
        cfg_pwm_inv = '0;
        step();

        for (int v = 0; v < 5; v++) begin
            set_ch(0, vecs[v].high, vecs[v].low, vecs[v].os);
            cfg_pwm_inv[0] = vecs[v].inv;
            restart(4'b0001);
            measure(vecs[v].n, vecs[v].inv, hi, lo, didx, dcnt, rises);
            check($sformatf("v%0d_high_ticks", v), 32'(hi), 32'(vecs[v].exp_high));
            check($sformatf("v%0d_low_ticks", v), 32'(lo), 32'(vecs[v].exp_low));
            check($sformatf("v%0d_done_idx", v), 32'(didx), 32'(vecs[v].exp_done_idx));
            check($sformatf("v%0d_done_cnt", v), 32'(dcnt), 32'(vecs[v].exp_done_cnt));
            check($sformatf("v%0d_rises", v), 32'(rises), 32'(vecs[v].exp_rise));
        end
        cfg_pwm_inv = '0;

        // One-shot re-arm by toggling enable
        set_ch(0, 16'd3, 16'd2, 1'b1);
        restart(4'b0001);
        measure(12, 1'b0, hi, lo, didx, dcnt, rises);
        restart(4'b0001);
        measure(12, 1'b0, hi, lo, didx, dcnt, rises);
        check("oneshot_rearm_high", 32'(hi), 32'd4);
        check("oneshot_rearm_done", 32'(dcnt), 32'd1);

        // Buffered update requested mid-HIGH takes effect at the next boundary
        set_ch(0, 16'd2, 16'd2, 1'b0);
        restart(4'b0001);
        got = '0;
        for (int k = 0; k < 16; k++) begin
            tick(wf, dn);
            got[15-k] = wf[0];
            if (k == 1) begin
                set_ch(0, 16'd5, 16'd1, 1'b0);
                cfg_pwm_upd[0] = 1'b1;
                step();
                cfg_pwm_upd[0] = 1'b0;
            end
        end
        check("upd_buffered", 32'(got), 32'(bits16("1110001111110011")));
        set_ch(0, 16'd1, 16'd1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick(wf, dn);
            got[15-k] = wf[0];
        end
        check("cfg_without_upd", 32'(got), 32'(bits16("1111001111110011")));

        // Sync coincident with a tick: both rise together, the tick is dropped
        set_ch(0, 16'd3, 16'd3, 1'b0);
        set_ch(1, 16'd7, 16'd1, 1'b0);
        restart(4'b0011);
        for (int k = 0; k < 5; k++) tick(wf, dn);
        check("pre_sync_phase", 32'(waveform[1:0]), 32'd2);
        cfg_pwm_sync = 1'b1;
        pulse1m_mclk = 1'b1;
        step();
        cfg_pwm_sync = 1'b0;
        pulse1m_mclk = 1'b0;
        check("sync_rise", 32'(waveform[1:0]), 32'd3);
        check("sync_no_done", 32'(pwm_done[1:0]), 32'd0);
        step();
        for (int k = 0; k < 3; k++) tick(wf, dn);
        check("sync_tick_ignored", 32'(wf[0]), 32'd1);
        tick(wf, dn);
        check("sync_high_end", 32'(wf[1:0]), 32'd2);
        cfg_pwm_inv[1] = 1'b1;
        step();
        check("inv_toggle", 32'(waveform[1:0]), 32'd0);
        cfg_pwm_inv = '0;
        step();

        // Asynchronous reset in mid-LOW, then restart with enables still high
        set_ch(0, 16'd2, 16'd2, 1'b0);
        set_ch(1, 16'd7, 16'd7, 1'b0);
        restart(4'b0011);
        for (int k = 0; k < 4; k++) tick(wf, dn);
        check("pre_reset_phase", 32'(wf[1:0]), 32'd2);
        h_reset = 1'b1;
        #1;
        check("async_reset_wave", 32'(waveform), 32'd0);
        check("async_reset_done", 32'(pwm_done), 32'd0);
        step();
        h_reset = 1'b0;
        step();
        tick(wf, dn);
        check("first_tick_after_reset", 32'(wf[1:0]), 32'd3);

        // Disable in mid-HIGH: low one edge later, no done pulse afterwards
        restart(4'b0001);
        tick(wf, dn);
        cfg_pwm_enb[0] = 1'b0;
        step();
        check("disable_wave", 32'(waveform[0]), 32'd0);
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick(wf, dn);
            if (dn[0] || wf[0]) dcnt++;
        end
        check("disabled_quiet", 32'(dcnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator, the successor to the single-channel pinmux PWM. It provides NCH independent channels with WIDTH-bit high/low counters and double-buffered configuration, so duty and period changes take effect only at period boundaries. Each channel also supports one-shot mode, output inversion and a per-period done pulse, and all channels can be phase-aligned by a global sync. It sits in the pinmux block, clocked by mclk and advanced by the shared 1 ms tick pulse1m_mclk.

## Interface
Parameters:
- NCH, 4, number of PWM channels (1..16)
- WIDTH, 16, width of the high/low phase counters (2..32)

Ports:
- mclk  in  1  system clock
- h_reset  in  1  asynchronous, active-high reset
- pulse1m_mclk  in  1  timebase tick, one mclk wide, 1 ms period
- cfg_pwm_enb  in  NCH  per-channel enable
- cfg_pwm_oneshot  in  NCH  1 = run a single period, then hold
- cfg_pwm_inv  in  NCH  1 = invert channel output
- cfg_pwm_high  in  NCH*WIDTH  high-phase length minus 1; channel c uses bits [c*WIDTH +: WIDTH]
- cfg_pwm_low  in  NCH*WIDTH  low-phase length minus 1; same packing as cfg_pwm_high
- cfg_pwm_upd  in  NCH  one-cycle pulse requesting a boundary reload of high/low
- cfg_pwm_sync  in  1  one-cycle pulse that restarts all enabled channels together
- waveform  out  NCH  registered PWM outputs
- pwm_done  out  NCH  one-cycle pulse at the end of each completed period

## Operation
Each channel has:
- An FSM with states IDLE, HIGH, LOW, DONE.
- A WIDTH-bit down counter cnt.
- Active registers act_high and act_low.
- An update-pending flag upd_pend.
- A raw wave bit.

Output rule: waveform[c] is registered as wave ^ cfg_pwm_inv[c].

Per-channel event priority, highest first:
1. h_reset: all state, counters, active registers and flags clear to 0; outputs go to 0.
2. cfg_pwm_enb[c] = 0: on the next mclk edge, independent of the tick, go to IDLE with cnt = 0, wave = 0, upd_pend = 0.
3. cfg_pwm_sync = 1 with the channel enabled and not in DONE: load act_high and act_low from cfg, set cnt = cfg high, wave = 1, go to HIGH, clear upd_pend.
4. pulse1m_mclk = 1 with the channel enabled: advance the FSM as follows.

Tick transitions:
- IDLE: act_* <= cfg_*, cnt <= cfg high, wave <= 1, go to HIGH.
- HIGH, cnt != 0: cnt <= cnt - 1.
- HIGH, cnt == 0: cnt <= act_low, wave <= 0, go to LOW.
- LOW, cnt != 0: cnt <= cnt - 1.
- LOW, cnt == 0 (period end): pwm_done[c] pulses for one cycle.
  - Oneshot = 1: go to DONE with wave = 0.
  - Oneshot = 0: go to HIGH with wave = 1. If upd_pend is set, first load act_* from cfg, set cnt = new high and clear upd_pend; otherwise cnt = act_high.
- DONE: hold with wave = 0. Only disabling the channel leaves DONE; it returns to IDLE.

Configuration and arithmetic rules:
- While the channel is in IDLE, act_* continuously track cfg_*.
- cfg_pwm_upd[c] sets upd_pend. A pulse coincident with a period-end reload is consumed by that reload: upd_pend ends at 0 and the new cfg values are used.
- Changes to cfg_pwm_high/low while running never affect the current period.
- The high phase lasts act_high + 1 ticks and the low phase act_low + 1 ticks; period = act_high + act_low + 2 ticks.
- Counters never wrap: a decrement happens only when cnt != 0.
- A value of 0 gives a 1-tick phase; the maximum is 2^WIDTH ticks.
- cfg_pwm_inv is applied combinationally before the output register, so a toggle appears on waveform on the next mclk edge at any time.

## Timing
- Reset values: waveform = 0, pwm_done = 0. With cfg_pwm_inv = 1, waveform goes to 1 on the first mclk edge after h_reset falls.
- Enabled in IDLE: waveform rises on the mclk edge that samples the first tick, i.e. 1 mclk of latency from the tick.
- pwm_done is asserted in the mclk cycle immediately after the period-end tick, for exactly one cycle.
- Disable: waveform = inv value one mclk after cfg_pwm_enb falls, even in mid-phase.
- Sync: all enabled channels show a rising raw wave on the same mclk edge, one cycle after cfg_pwm_sync. When sync and a tick coincide, sync wins and the tick is not counted.
- Channels are fully independent apart from the shared tick and sync.

## Test plan
- Basic duty: NCH = 4, WIDTH = 16, ch0 high = 499, low = 499, 1000 ticks -> waveform[0] high for 500 ticks then low for 500; pwm_done[0] pulses once, on the cycle after tick 1000.
- Minimum phases: high = 0, low = 998 -> 1 tick high and 999 low, repeating. high = 0, low = 0 -> output toggles every tick, period of 2 ticks.
- Buffered update: running at 2/2, change cfg to 5/1 and pulse cfg_pwm_upd mid-HIGH -> current period stays 3/3 ticks, next period is 6/2. Change without the upd pulse -> the period never changes.
- One-shot: oneshot = 1, high = 3, low = 2 -> exactly 4 ticks high, 3 low, then one pwm_done pulse and waveform held at 0 for 20 more ticks. Toggling enable off and on -> a new single period.
- Sync and inversion: ch0 at 3/3 and ch1 at 7/1, both running, pulse cfg_pwm_sync coincident with a tick -> both waveforms rise on the same edge and the tick is ignored. Setting inv[1] = 1 -> waveform[1] is the complement of its raw wave from the next edge.
- Reset and disable mid-operation: assert h_reset in mid-LOW -> all outputs go to 0 immediately; releasing with enables high -> waveforms rise on the first tick. Deassert enb mid-HIGH -> 0 one mclk later with no pwm_done pulse.
